// File: rtl/cipher_word_serializer_if.sv
// rtl/cipher_word_serializer_if.sv - block-in / word-out handshake bundle for the cipher word serializer
interface cipher_word_serializer_if #(
  parameter int DATA_WIDTH = 128,
  parameter int WORD_WIDTH = 32
);
  logic                  ser_valid_in;
  logic [DATA_WIDTH-1:0] ser_data_in;
  logic                  ser_ready_out;
  logic [WORD_WIDTH-1:0] ser_data_out;
  logic                  ser_valid_out;
  logic                  ser_ready_in;
  logic                  ser_last_out;

  modport slave (
    input  ser_valid_in,
    input  ser_data_in,
    input  ser_ready_in,
    output ser_ready_out,
    output ser_data_out,
    output ser_valid_out,
    output ser_last_out
  );

  modport master (
    output ser_valid_in,
    output ser_data_in,
    output ser_ready_in,
    input  ser_ready_out,
    input  ser_data_out,
    input  ser_valid_out,
    input  ser_last_out
  );
endinterface

// File: rtl/cipher_word_serializer.sv
// rtl/cipher_word_serializer.sv - buffers ciphertext blocks in a small FIFO and emits them MSW-first as words
module cipher_word_serializer #(
  parameter int DATA_WIDTH = 128,
  parameter int WORD_WIDTH = 32,
  parameter int FIFO_DEPTH = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  cipher_word_serializer_if.slave   ser,
  output logic                      overflow,
  output logic [15:0]               block_count
);
  localparam int WORDS = DATA_WIDTH / WORD_WIDTH;
  localparam int IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(FIFO_DEPTH - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);

  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic [CNT_W-1:0]      count;
  logic [IDX_W-1:0]      word_idx;

  logic [DATA_WIDTH-1:0] head;
  logic [WORD_WIDTH-1:0] head_words [WORDS];
  logic                  valid;
  logic                  last_word;
  logic                  xfer;
  logic                  pop;
  logic                  ready;
  logic                  push;
  logic                  drop;

  function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? '0 : p + 1'b1;
  endfunction

  assign head = mem[rd_ptr];

  // Word 0 is the most significant slice of the block.
  for (genvar k = 0; k < WORDS; k++) begin : g_words
    assign head_words[k] = head[DATA_WIDTH-1-k*WORD_WIDTH -: WORD_WIDTH];
  end

  assign valid     = (count != '0);
  assign last_word = valid && (word_idx == LAST_IDX);
  assign xfer      = valid && ser.ser_ready_in;
  assign pop       = xfer && last_word;
  assign ready     = (count < FULL_CNT) || pop;
  assign push      = rst && ser.ser_valid_in && ready;
  assign drop      = ser.ser_valid_in && !ready;

  assign ser.ser_valid_out = valid;
  assign ser.ser_data_out  = valid ? head_words[word_idx] : '0;
  assign ser.ser_last_out  = last_word;
  assign ser.ser_ready_out = ready;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= ser.ser_data_in;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      word_idx    <= '0;
      overflow    <= 1'b0;
      block_count <= '0;
    end else begin
      if (push) wr_ptr <= ptr_next(wr_ptr);
      if (pop) begin
        rd_ptr      <= ptr_next(rd_ptr);
        block_count <= block_count + 16'd1;
      end
      if (xfer) word_idx <= last_word ? '0 : word_idx + 1'b1;
      // A push coinciding with the final-word pop leaves occupancy unchanged.
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (drop) overflow <= 1'b1;
    end
  end
endmodule

// File: doc/cipher_word_serializer.md
CIPHER_WORD_SERIALIZER -- requirements
Module: cipher_word_serializer

Interface
REQ-001 Parameter DATA_WIDTH, default 128: width of the ciphertext block from the final AES round; fixed at 128.
REQ-002 Parameter WORD_WIDTH, default 32: output word width; DATA_WIDTH/WORD_WIDTH = 4 words per block.
REQ-003 Parameter FIFO_DEPTH, default 2: number of 128-bit blocks buffered.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst  input  1  synchronous, active-low reset.
REQ-006 ser_valid_in  input  1  ciphertext block on ser_data_in is valid; driven by the last-round valid output; the source has no backpressure.
REQ-007 ser_data_in  input  DATA_WIDTH  ciphertext block; bits [127:96] are word 0.
REQ-008 ser_ready_out  output  1  advisory: a block presented this cycle will be accepted.
REQ-009 ser_data_out  output  WORD_WIDTH  current output word.
REQ-010 ser_valid_out  output  1  ser_data_out is valid.
REQ-011 ser_ready_in  input  1  downstream consumer accepts the word this cycle.
REQ-012 ser_last_out  output  1  high with the 4th (final) word of a block.
REQ-013 overflow  output  1  sticky flag: a valid block was dropped.
REQ-014 block_count  output  16  number of blocks fully emitted (last word handshaken).

Function
REQ-015 Storage shall be a circular FIFO of FIFO_DEPTH entries with write pointer, read pointer and occupancy count 0..FIFO_DEPTH.
REQ-016 Word index: 2-bit counter selecting head word; word k = head[127-32k -: 32].
REQ-017 Output handshake: word transfers on a cycle where ser_valid_out && ser_ready_in.
REQ-018 ser_valid_out = (count != 0); ser_data_out = selected head word when valid, 0 when count == 0.
REQ-019 ser_last_out = ser_valid_out && (word index == 3).
REQ-020 While ser_valid_out && !ser_ready_in, ser_data_out, ser_last_out and word index shall hold.
REQ-021 On a word transfer with index < 3: index increments; FIFO unchanged.
REQ-022 On a word transfer with index == 3: index -> 0, read pointer advances, count decrements, block_count increments (wraps 0xFFFF -> 0x0000).
REQ-023 ser_ready_out = (count < FIFO_DEPTH) || (ser_valid_out && ser_ready_in && ser_last_out), combinational.
REQ-024 Push: ser_valid_in && ser_ready_out writes ser_data_in at write pointer, advances write pointer, increments count.
REQ-025 Simultaneous push and final-word pop: count unchanged, both pointers advance, pushed data not corrupted.
REQ-026 Drop: ser_valid_in && !ser_ready_out discards the block, FIFO unchanged, overflow set next cycle; overflow cleared only by reset.
REQ-027 Latency: block pushed into empty FIFO on edge N -> word 0 valid on ser_data_out in the cycle after edge N (1 cycle); no combinational path from ser_data_in to ser_data_out.
REQ-028 Throughput: with ser_ready_in held high, one word per cycle, back-to-back blocks with no bubble.
REQ-029 Pointers wrap modulo FIFO_DEPTH; count never exceeds FIFO_DEPTH nor underflows.

Reset
REQ-030 While rst == 0 at a rising edge: count, pointers, word index, overflow, block_count -> 0; ser_valid_out = 0, ser_last_out = 0, ser_data_out = 0.
REQ-031 Reset mid-block discards all buffered blocks and any partially emitted block; ser_valid_in is ignored during reset cycles.
REQ-032 Storage array contents need not be reset.

Verification
REQ-033 Single block 128'h3925841d02dc09fbdc118597196a0b32, ser_ready_in = 1 -> words 3925841d, 02dc09fb, dc118597, 196a0b32 on 4 consecutive cycles starting 1 cycle after push, ser_last_out only on 196a0b32, block_count = 1.
REQ-034 Same block, ser_ready_in low for 3 cycles during word 1 -> 02dc09fb held stable, no word skipped or repeated.
REQ-035 Three blocks on consecutive cycles with ser_ready_in = 0 -> first two accepted, third dropped, ser_ready_out = 0 on third cycle, overflow = 1 and stays 1; after release exactly 8 words emitted, block_count = 2.
REQ-036 FIFO full, new block presented on the cycle the head's final word handshakes -> block accepted, count stays 2, no overflow, 12 words total emitted in order.
REQ-037 rst asserted after word 1 of a buffered block -> next cycle ser_valid_out = 0, overflow = 0, block_count = 0; new block after release emits from word 0.
REQ-038 Continuous stream of 20 blocks, one every 4 cycles, ser_ready_in = 1 -> 80 words with no bubbles, overflow = 0, block_count = 20.
